// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op codes, datapath width, legality check.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9,
    NONE = 4'd10,
    EQ   = 4'd11,
    BGE  = 4'd12,
    BGEU = 4'd13
  } alu_op_t;

  // NONE and the two unassigned codes at the top of the range are illegal.
  function automatic logic is_legal_op(input logic [3:0] op);
    return !(op == NONE || op >= 4'd14);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational integer ALU shared by all requesters; also exports signed gt / eq flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] res_o,
  output logic             gt_o,
  output logic             eq_o
);

  alu_op_t    op;
  logic [4:0] shamt;

  assign op    = alu_op_t'(op_i);
  assign shamt = b_i[4:0];
  assign gt_o  = $signed(a_i) > $signed(b_i);
  assign eq_o  = (a_i == b_i);

  // Op decode; codes resolved outside the ALU (BGE, BGEU, illegal) yield 0 here.
  always_comb begin
    res_o = '0;
    case (op)
      ADD:     res_o = a_i + b_i;
      SUB:     res_o = a_i - b_i;
      SLL:     res_o = a_i << shamt;
      SLT:     res_o = {{(ALU_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      SLTU:    res_o = {{(ALU_W-1){1'b0}}, a_i < b_i};
      XOR:     res_o = a_i ^ b_i;
      SRL:     res_o = a_i >> shamt;
      SRA:     res_o = $signed(a_i) >>> shamt;
      OR:      res_o = a_i | b_i;
      AND:     res_o = a_i & b_i;
      EQ:      res_o = {{(ALU_W-1){1'b0}}, eq_o};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping modulo NUM_REQ.
// Latency: grant is combinational; pointer moves one past the winner on the edge after an accepted grant.
// Backpressure: enable_i low suppresses every grant and freezes the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               enable_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   cand;
  logic            found;

  // Scan from the pointer upward; the extra bit in cand absorbs the wrap before reducing mod NUM_REQ.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (enable_i && !found && req_i[cand[ID_W-1:0]]) begin
        found                     = 1'b1;
        gnt_idx_o                 = cand[ID_W-1:0];
        gnt_o[cand[ID_W-1:0]]     = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (gnt_idx_o == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_o + ID_W'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters; round-robin grant, tagged registered response.
// Latency: 1 cycle accept-to-rsp_valid, 1 op/cycle while rsp_ready is high.
// Backpressure: a held response (rsp_valid && !rsp_ready) drops every req_ready. Optional ALU_ARB_PERF_EN adds counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_op,
  input  logic [NUM_REQ*ALU_W-1:0] req_a,
  input  logic [NUM_REQ*ALU_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [ALU_W-1:0]         rsp_data,
  output logic                     rsp_err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]    perf_grants,
  output logic [31:0]              perf_stall
`endif
);

  logic               slot_free;
  logic               xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;

  logic [3:0]         op_sel;
  logic [ALU_W-1:0]   a_sel, b_sel;
  logic [ALU_W-1:0]   alu_res;
  logic               alu_gt, alu_eq;
  logic [ALU_W-1:0]   op_res;
  logic               op_err;

  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  // A new response may load when the register is empty or being drained this cycle.
  // Gating with rst_n keeps req_ready low for the whole reset.
  assign slot_free = !rsp_valid_q || rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .enable_i  (slot_free && rst_n),
    .advance_i (xfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);

  // One-hot payload mux driven only by the grant, so ready never depends on the payload.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_sel = req_op[i*4 +: 4];
        a_sel  = req_a[i*ALU_W +: ALU_W];
        b_sel  = req_b[i*ALU_W +: ALU_W];
      end
    end
  end

  alu u_alu (
    .op_i  (op_sel),
    .a_i   (a_sel),
    .b_i   (b_sel),
    .res_o (alu_res),
    .gt_o  (alu_gt),
    .eq_o  (alu_eq)
  );

  // Result select: illegal ops bypass the ALU, BGEU is a local unsigned compare, BGE reuses gt|eq.
  always_comb begin
    op_res = alu_res;
    op_err = 1'b0;
    if (!is_legal_op(op_sel)) begin
      op_res = '0;
      op_err = 1'b1;
    end else if (op_sel == BGEU) begin
      op_res = {{(ALU_W-1){1'b0}}, a_sel >= b_sel};
    end else if (op_sel == BGE) begin
      op_res = {{(ALU_W-1){1'b0}}, alu_gt | alu_eq};
    end
  end

  // Response next-state: load on transfer, clear valid on a pure drain, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_data_d  = op_res;
      rsp_err_d   = op_err;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response register; reset discards any pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q;

  // Saturating per-requester grant counters and a stall counter (requests waiting, none granted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && req_valid[i] && grant_cnt_q[i] != '1) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
      end
      if (|req_valid && !xfer && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    assign perf_grants[gi*32 +: 32] = grant_cnt_q[gi];
  end
  assign perf_stall = stall_cnt_q;
`else
  // Counters are not built; the datapath above is the whole block.
`endif

`ifndef SYNTHESIS
  // Requesters must hold valid and a stable payload until accepted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_chk
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
      req_valid[gi] && !req_ready[gi] |=> req_valid[gi]);
    a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
      req_valid[gi] && !req_ready[gi] |=> $stable(req_op[gi*4 +: 4]) &&
        $stable(req_a[gi*ALU_W +: ALU_W]) && $stable(req_b[gi*ALU_W +: ALU_W]));
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench with a queue-free behavioural model of the arbiter, checked on every falling edge.
// Latency: model predicts the response one edge after each grant it computes.
// Backpressure: rsp_ready is randomized; requesters hold until accepted.
module tb_alu_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*4-1:0]  req_op;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_data;
  logic            rsp_err;
`ifdef ALU_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_stall;
`endif

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] accepted = '0;
  int           fair_id   [4] = '{0, 1, 2, 0};
  logic [31:0]  fair_data [4] = '{32'd7, 32'hFF, 32'd1, 32'd7};

  alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_illegal(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd14) || (op == 4'd15);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b[4:0];
      4'd3:    r = {31'b0, $signed(a) < $signed(b)};
      4'd4:    r = {31'b0, a < b};
      4'd5:    r = a ^ b;
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $signed(a) >>> b[4:0];
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      4'd11:   r = {31'b0, a == b};
      4'd12:   r = {31'b0, $signed(a) >= $signed(b)};
      4'd13:   r = {31'b0, a >= b};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Behavioural model: response slot contents and a round-robin pointer, advanced once per cycle.
  initial begin : model
    logic        m_v;
    int          m_id;
    logic [31:0] m_d;
    logic        m_e;
    int          m_ptr;
    int          g;
    int          idx;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] m_pg [N];
    logic [31:0] m_ps;
`endif
    m_v = 0; m_id = 0; m_d = 0; m_e = 0; m_ptr = 0;
`ifdef ALU_ARB_PERF_EN
    for (int i = 0; i < N; i++) m_pg[i] = 0;
    m_ps = 0;
`endif
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_v = 0; m_id = 0; m_d = 0; m_e = 0; m_ptr = 0;
`ifdef ALU_ARB_PERF_EN
        for (int i = 0; i < N; i++) m_pg[i] = 0;
        m_ps = 0;
`endif
      end
      chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_v});
      chk("m_rsp_id", 32'(rsp_id), m_id);
      chk("m_rsp_data", rsp_data, m_d);
      chk("m_rsp_err", {31'b0, rsp_err}, {31'b0, m_e});
      g = -1;
      if (rst_n && (!m_v || rsp_ready)) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      chk("m_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
`ifdef ALU_ARB_PERF_EN
      for (int i = 0; i < N; i++) chk("m_perf_grants", perf_grants[i*32 +: 32], m_pg[i]);
      chk("m_perf_stall", perf_stall, m_ps);
      if (rst_n) begin
        if (g >= 0) m_pg[g] = m_pg[g] + 1;
        else if (req_valid != 0) m_ps = m_ps + 1;
      end
`endif
      accepted = req_valid & req_ready;
      if (g >= 0) begin
        m_v   = 1;
        m_id  = g;
        m_d   = ref_alu(req_op[g*4 +: 4], req_a[g*32 +: 32], req_b[g*32 +: 32]);
        m_e   = ref_illegal(req_op[g*4 +: 4]);
        m_ptr = (g + 1) % N;
      end else if (rst_n && rsp_ready) begin
        m_v = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_op[i*4 +: 4]   = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  // Called just after a rising edge; returns just after the edge that loaded the response.
  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 0;
    set_req(i, op, a, b);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (req_ready[i]) done = 1;
    end
    chk("issue_accept", {31'b0, done}, 32'd1);
    step();
    req_valid[i] = 1'b0;
  endtask

  // Withdraw each request only after it has been accepted.
  task automatic drain_reqs();
    for (int t = 0; t < 40 && req_valid != 0; t++) begin
      step();
      req_valid = req_valid & ~accepted;
    end
    chk("drain_reqs", 32'(req_valid), 32'd0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;

    // Pin the reference model with hand-computed values.
    chk("ref_sra", ref_alu(4'd7, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("ref_sltu", ref_alu(4'd4, 32'd1, 32'hFFFF_FFFF), 32'd1);
    chk("ref_slt", ref_alu(4'd3, 32'd1, 32'hFFFF_FFFF), 32'd0);
    chk("ref_bge", ref_alu(4'd12, 32'hFFFF_FFFF, 32'd1), 32'd0);

    // Reset state, with requests present.
    req_valid = 3'b111;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single requester ADD 5+7.
    rsp_ready = 1'b1;
    issue(0, 4'd0, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_valid", {31'b0, rsp_valid}, 32'd1);
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_data", rsp_data, 32'd12);
    chk("add_err", {31'b0, rsp_err}, 32'd0);

    // Fairness with all three requesters held high.
    do_reset();
    set_req(0, 4'd1, 32'd10, 32'd3);
    set_req(1, 4'd5, 32'hF0, 32'h0F);
    set_req(2, 4'd3, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fair_valid", {31'b0, rsp_valid}, 32'd1);
      chk("fair_id", 32'(rsp_id), fair_id[k]);
      chk("fair_data", rsp_data, fair_data[k]);
    end
    drain_reqs();
    step();
    step();

    // Backpressure: response held four cycles while req1 waits.
    rsp_ready = 1'b0;
    set_req(0, 4'd0, 32'd1, 32'd2);
    @(negedge clk);
    chk("bp_first_grant", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    set_req(1, 4'd0, 32'd100, 32'd23);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_hold_data", rsp_data, 32'd3);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'b010);
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_b2b_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_b2b_id", 32'(rsp_id), 32'd1);
    chk("bp_b2b_data", rsp_data, 32'd123);

    // Illegal ops and the compare ops.
    step();
    issue(2, 4'd10, 32'h1234, 32'h5678);
    @(negedge clk);
    chk("none_err", {31'b0, rsp_err}, 32'd1);
    chk("none_data", rsp_data, 32'd0);
    step();
    issue(1, 4'd15, 32'd9, 32'd9);
    @(negedge clk);
    chk("op15_err", {31'b0, rsp_err}, 32'd1);
    step();
    issue(0, 4'd13, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("bgeu_data", rsp_data, 32'd1);
    chk("bgeu_err", {31'b0, rsp_err}, 32'd0);
    step();
    issue(1, 4'd12, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("bge_data", rsp_data, 32'd0);

    // Reset while a response is stalled.
    step();
    rsp_ready = 1'b0;
    issue(1, 4'd0, 32'd2, 32'd3);
    set_req(1, 4'd0, 32'd9, 32'd9);
    set_req(2, 4'd0, 32'd4, 32'd4);
    #2;
    chk("mid_rst_valid_before", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_async", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_first_grant", 32'(req_ready), 32'b010);
    drain_reqs();

    // Randomized traffic with random backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || accepted[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            set_req(i, 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
      end
    end
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    drain_reqs();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
